// File: rtl/psum_requant_stream.sv
// Requantises final PE partial sums (rounding shift, optional ReLU, saturation) and
// streams them out through a small FIFO as an AXI-Stream master with framed tlast.
module psum_requant_stream #(
    parameter int SUM_BW     = 16,
    parameter int OUT_BW     = 8,
    parameter int SHIFT_BW   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_BW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SHIFT_BW-1:0]      i_cfg_shift,
    input  logic                     i_cfg_relu,
    input  logic [CNT_BW-1:0]        i_cfg_len,
    input  logic                     i_clr_ovf,
    input  logic                     i_valid,
    input  logic signed [SUM_BW:0]   i_psum,
    output logic                     o_ready,
    output logic signed [OUT_BW-1:0] o_tdata,
    output logic                     o_tvalid,
    input  logic                     i_tready,
    output logic                     o_tlast,
    output logic                     o_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int EXT_W = SUM_BW + 2;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

    // Half-LSB bias added before the arithmetic shift, so ties go toward +inf.
    function automatic logic signed [EXT_W-1:0] round_shift(
        input logic signed [SUM_BW:0]   psum,
        input logic [SHIFT_BW-1:0]      sh
    );
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] sum;
        ext = {psum[SUM_BW], psum};
        rnd = '0;
        if (sh != '0) begin
            rnd = EXT_W'(1) << (sh - SHIFT_BW'(1));
        end
        sum = ext + rnd;
        return sum >>> sh;
    endfunction

    function automatic logic signed [OUT_BW-1:0] relu_saturate(
        input logic signed [EXT_W-1:0] r,
        input logic                    relu
    );
        logic signed [OUT_BW-1:0] res;
        if (relu && (r < 0)) begin
            res = '0;
        end else if (r > SAT_MAX) begin
            res = SAT_MAX[OUT_BW-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[OUT_BW-1:0];
        end else begin
            res = r[OUT_BW-1:0];
        end
        return res;
    endfunction

    logic                     s1_vld_p1;
    logic signed [OUT_BW-1:0] s1_data_p1;

    logic signed [OUT_BW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     accept;
    logic                     drop;

    logic [CNT_BW-1:0]        beat_cnt;
    logic [CNT_BW-1:0]        last_idx;

    // o_ready reserves a slot for the stage-1 entry still in flight.
    assign o_ready    = (fifo_count + CNT_W'(s1_vld_p1)) < CNT_W'(FIFO_DEPTH);
    assign accept     = i_valid & o_ready;
    assign drop       = i_valid & ~o_ready;

    assign fifo_empty = (fifo_count == '0);
    assign o_tvalid   = ~fifo_empty;
    assign o_tdata    = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign push       = s1_vld_p1;
    assign pop        = o_tvalid & i_tready;

    assign last_idx   = (i_cfg_len == '0) ? '0 : (i_cfg_len - CNT_BW'(1));
    assign o_tlast    = o_tvalid & (beat_cnt == last_idx);

    // ---- stage 0 -> stage 1: requantise the accepted psum ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_p1 <= 1'b0;
        end else begin
            s1_vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data_p1 <= relu_saturate(round_shift(i_psum, i_cfg_shift), i_cfg_relu);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

    // ---- stage 1 -> stage 2: output FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s1_data_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (o_tlast) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_BW'(1);
            end
        end
    end

endmodule
